// File: rtl/ternary_mvm_pkg.sv
// Shared types and constants for the ternary matrix-vector engine.
package ternary_mvm_pkg;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMP, S_OUT} state_t;

    typedef struct packed {
        logic [6:0] in_len;
        logic [6:0] out_len;
    } dims_t;

    localparam logic [3:0] CMD_LOAD = 4'hA;
    localparam logic [3:0] CMD_COMP = 4'hC;

    localparam logic [1:0] W_POS = 2'b01;
    localparam logic [1:0] W_NEG = 2'b11;

    function automatic logic signed [1:0] decode_w(input logic [1:0] code);
        case (code)
            W_POS:   return 2'sb01;
            W_NEG:   return 2'sb11;
            default: return 2'sb00;
        endcase
    endfunction

endpackage

// File: rtl/ternary_acc_lane.sv
// One row accumulator: clear, enable, up to two ternary MACs per beat, saturating to ACC_W.
module ternary_acc_lane
    import ternary_mvm_pkg::*;
#(
    parameter int ACT_W   = 8,
    parameter int ACC_W   = 16,
    parameter int NUM_MAC = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr,
    input  logic                              en,
    input  logic [NUM_MAC-1:0][1:0]           codes,
    input  logic [NUM_MAC-1:0][ACT_W-1:0]     acts,
    input  logic [NUM_MAC-1:0]                act_en,
    output logic [ACC_W-1:0]                  acc
);

    localparam int SW = ACC_W + 2;

    logic [SW-1:0]    sum;
    logic [ACC_W-1:0] sat_val;

    always_comb begin
        sum = {{2{acc[ACC_W-1]}}, acc};
        for (int j = 0; j < NUM_MAC; j++) begin
            if (act_en[j]) begin
                case (decode_w(codes[j]))
                    2'sb01:  sum = sum + {{(SW-ACT_W){acts[j][ACT_W-1]}}, acts[j]};
                    2'sb11:  sum = sum - {{(SW-ACT_W){acts[j][ACT_W-1]}}, acts[j]};
                    default: ;
                endcase
            end
        end
        // Top three bits agreeing means the wide sum still fits in ACC_W.
        if ((&sum[SW-1:ACC_W-1]) || !(|sum[SW-1:ACC_W-1]))
            sat_val = sum[ACC_W-1:0];
        else if (sum[SW-1])
            sat_val = {1'b1, {(ACC_W-1){1'b0}}};
        else
            sat_val = {1'b0, {(ACC_W-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= sat_val;
    end

endmodule

// File: rtl/ternary_mvm_engine.sv
// Ternary matrix-vector engine: LOAD weights, COMP activations, OUT saturated row sums.
// Define MVM_RELU_EN to clamp emitted results at zero.
module ternary_mvm_engine
    import ternary_mvm_pkg::*;
#(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int ACT_W       = 8,
    parameter int ACC_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int APW    = 16 / ACT_W;
    localparam int APW_SH = (APW == 2) ? 1 : 0;
    localparam int CW     = $clog2(MAX_IN_LEN);
    localparam int RW     = $clog2(MAX_OUT_LEN);
    localparam logic [6:0] MAX_IN  = 7'(MAX_IN_LEN);
    localparam logic [6:0] MAX_OUT = 7'(MAX_OUT_LEN);

    state_t state, state_n;
    dims_t  dims;
    logic [6:0] row_cnt, word_cnt, out_row;
    logic [6:0] cfg_in, cfg_out, row_words, comp_words;
    logic       in_fire, out_fire;
    logic       load_last, comp_last, out_last, acc_clr, acc_en;

    logic [MAX_OUT_LEN-1:0][MAX_IN_LEN-1:0][1:0] weights;
    logic [MAX_OUT_LEN-1:0][ACC_W-1:0]           acc;
    logic [MAX_OUT_LEN-1:0][APW-1:0][1:0]        lane_codes;
    logic [APW-1:0][ACT_W-1:0]                   acts;
    logic [APW-1:0]                              act_en;
    logic [ACC_W-1:0]                            out_res, out_sel;

    assign in_ready  = (state != S_OUT);
    assign out_valid = (state == S_OUT);
    assign busy      = (state != S_IDLE);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign cfg_in     = {1'b0, in_data[11:6]} + 7'd1;
    assign cfg_out    = {1'b0, in_data[5:0]} + 7'd1;
    assign row_words  = (dims.in_len + 7'd7) >> 3;
    assign comp_words = (dims.in_len + 7'(APW - 1)) >> APW_SH;

    always_comb begin
        state_n   = state;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        load_last = 1'b0;
        comp_last = 1'b0;
        out_last  = 1'b0;
        case (state)
            S_IDLE: if (in_fire) begin
                if (in_data[15:12] == CMD_LOAD) begin
                    state_n = S_LOAD;
                end else if (in_data[15:12] == CMD_COMP) begin
                    state_n = S_COMP;
                    acc_clr = 1'b1;
                end
            end
            S_LOAD: if (in_fire) begin
                load_last = (row_cnt == dims.out_len - 7'd1) && (word_cnt == row_words - 7'd1);
                if (load_last) state_n = S_IDLE;
            end
            S_COMP: if (in_fire) begin
                acc_en    = 1'b1;
                comp_last = (word_cnt == comp_words - 7'd1);
                if (comp_last) state_n = S_OUT;
            end
            S_OUT: if (out_fire) begin
                out_last = (out_row == dims.out_len - 7'd1);
                if (out_last) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            dims     <= '{in_len: MAX_IN, out_len: MAX_OUT};
            row_cnt  <= '0;
            word_cnt <= '0;
            out_row  <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_n;
            done  <= load_last || out_last;
            case (state)
                S_IDLE: begin
                    row_cnt  <= '0;
                    word_cnt <= '0;
                    out_row  <= '0;
                    if (in_fire && in_data[15:12] == CMD_LOAD) begin
                        dims.in_len  <= (cfg_in > MAX_IN) ? MAX_IN : cfg_in;
                        dims.out_len <= (cfg_out > MAX_OUT) ? MAX_OUT : cfg_out;
                    end
                end
                S_LOAD: if (in_fire) begin
                    if (word_cnt == row_words - 7'd1) begin
                        word_cnt <= '0;
                        row_cnt  <= row_cnt + 7'd1;
                    end else begin
                        word_cnt <= word_cnt + 7'd1;
                    end
                end
                S_COMP: if (in_fire) word_cnt <= word_cnt + 7'd1;
                S_OUT:  if (out_fire) out_row <= out_row + 7'd1;
                default: ;
            endcase
        end
    end

    // Each load word writes eight columns of the current row, even past in_len.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weights <= '0;
        end else if (state == S_LOAD && in_fire) begin
            for (int k = 0; k < 8; k++)
                if (int'(word_cnt) * 8 + k < MAX_IN_LEN)
                    weights[row_cnt[RW-1:0]][CW'(int'(word_cnt) * 8 + k)] <= in_data[2*k +: 2];
        end
    end

    always_comb begin
        lane_codes = '0;
        acts       = '0;
        act_en     = '0;
        for (int j = 0; j < APW; j++) begin
            acts[j]   = in_data[j*ACT_W +: ACT_W];
            act_en[j] = (int'(word_cnt) * APW + j) < int'(dims.in_len);
            for (int r = 0; r < MAX_OUT_LEN; r++)
                if ((int'(word_cnt) * APW + j) < MAX_IN_LEN)
                    lane_codes[r][j] = weights[r][CW'(int'(word_cnt) * APW + j)];
        end
    end

    for (genvar r = 0; r < MAX_OUT_LEN; r++) begin : g_lane
        ternary_acc_lane #(
            .ACT_W   (ACT_W),
            .ACC_W   (ACC_W),
            .NUM_MAC (APW)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (acc_clr),
            .en     (acc_en),
            .codes  (lane_codes[r]),
            .acts   (acts),
            .act_en (act_en),
            .acc    (acc[r])
        );
    end

    assign out_res = acc[out_row[RW-1:0]];
`ifdef MVM_RELU_EN
    assign out_sel = out_res[ACC_W-1] ? '0 : out_res;
`else
    assign out_sel = out_res;
`endif
    assign out_data = out_valid ? out_sel : '0;

endmodule

// File: tb/tb_ternary_mvm_engine.sv
// Randomised bench for ternary_mvm_engine against a transaction-level matrix model.
module tb_ternary_mvm_engine;

    localparam int MAXIN  = 64;
    localparam int MAXOUT = 8;
    localparam int ACC_W  = 12;
    localparam int P_IDLE = 0, P_LOAD = 1, P_COMP = 2, P_OUT = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [15:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             done;

    ternary_mvm_engine #(
        .MAX_IN_LEN(MAXIN), .MAX_OUT_LEN(MAXOUT), .ACT_W(8), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int phase = P_IDLE;
    int m_in, m_out, stall = 0;
    bit mon_en = 1'b0, done_exp = 1'b0;
    int mw [MAXOUT][MAXIN];
    int tw [MAXOUT][MAXIN];
    int ta [MAXIN];
    int macc [MAXOUT];
    int exp_q[$];
    int got_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int dec(input int code);
        return (code == 1) ? 1 : (code == 3) ? -1 : 0;
    endfunction

    function automatic int sat(input int v);
        int lim = 1 << (ACC_W - 1);
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic int relu(input int v);
`ifdef MVM_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic model_reset();
        foreach (mw[r, c]) mw[r][c] = 0;
        m_in = MAXIN; m_out = MAXOUT;
        phase = P_IDLE; exp_q.delete(); done_exp = 1'b0; stall = 0;
    endtask

    // Compare process: checks every handshake-visible output each cycle and plays the sink.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", int'(in_ready), int'(phase != P_OUT));
            chk("out_valid", int'(out_valid), int'(phase == P_OUT));
            chk("busy", int'(busy), int'(phase != P_IDLE));
            chk("done", int'(done), int'(done_exp));
            done_exp = 1'b0;
            if (phase == P_OUT) begin
                if (exp_q.size() == 0) begin
                    chk("out beat count", 1, 0);
                    phase = P_IDLE;
                end else begin
                    chk("out_data", int'($signed(out_data)), exp_q[0]);
                    if (stall > 0) begin
                        out_ready = 1'b0;
                        stall--;
                    end else begin
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (out_ready) begin
                        got_q.push_back(int'($signed(out_data)));
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) begin
                            phase = P_IDLE;
                            done_exp = 1'b1;
                        end
                    end
                end
            end else begin
                out_ready = ($urandom_range(0, 1) != 0);
            end
        end
    end

    // Called just after a posedge; returns just after the posedge that accepted the word.
    task automatic send_word(input logic [15:0] w);
        int n = 0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_data = w; in_valid = 1'b1;
        while (!in_ready && n < 400) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL in_ready timeout: got 0 expected 1 within 400 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (phase != P_IDLE && n < 3000) begin @(posedge clk); #1; n++; end
        if (phase != P_IDLE) begin
            n_chk++; n_fail++;
            $display("FAIL idle timeout: phase %0d expected %0d", phase, P_IDLE);
        end
    endtask

    task automatic do_load(input int il, input int ol);
        int wpr;
        logic [15:0] w;
        send_word({4'hA, 6'(il), 6'(ol)});
        phase = P_LOAD;
        m_in  = (il + 1 > MAXIN) ? MAXIN : il + 1;
        m_out = (ol + 1 > MAXOUT) ? MAXOUT : ol + 1;
        wpr = (m_in + 7) / 8;
        for (int r = 0; r < m_out; r++)
            for (int c = 0; c < wpr; c++) begin
                for (int j = 0; j < 8; j++) begin
                    w[2*j +: 2] = 2'(tw[r][8*c + j]);
                    mw[r][8*c + j] = dec(tw[r][8*c + j]);
                end
                send_word(w);
            end
        phase = P_IDLE;
        done_exp = 1'b1;
    endtask

    task automatic do_comp();
        int nw, s;
        got_q.delete();
        send_word({4'hC, 12'($urandom)});
        phase = P_COMP;
        foreach (macc[r]) macc[r] = 0;
        nw = (m_in + 1) / 2;
        for (int k = 0; k < nw; k++) begin
            send_word({8'(ta[2*k + 1]), 8'(ta[2*k])});
            for (int r = 0; r < MAXOUT; r++) begin
                s = 0;
                for (int j = 0; j < 2; j++)
                    if (2*k + j < m_in) s += mw[r][2*k + j] * ta[2*k + j];
                macc[r] = sat(macc[r] + s);
            end
        end
        for (int r = 0; r < m_out; r++) exp_q.push_back(relu(macc[r]));
        phase = P_OUT;
    endtask

    task automatic async_reset(input string nm);
        @(posedge clk); #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({nm, " in_ready"}, int'(in_ready), 1);
        chk({nm, " out_valid"}, int'(out_valid), 0);
        chk({nm, " out_data"}, int'(out_data), 0);
        chk({nm, " busy"}, int'(busy), 0);
        chk({nm, " done"}, int'(done), 0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    task automatic check_all(input string nm, input int n, input int v);
        chk({nm, " beats"}, got_q.size(), n);
        foreach (got_q[i]) chk(nm, got_q[i], v);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data", int'(out_data), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // all +1 weights, all activations 1, 16x8
        foreach (tw[r, c]) tw[r][c] = 1;
        do_load(15, 7);
        foreach (ta[i]) ta[i] = 1;
        do_comp(); wait_idle();
        check_all("t1 row", 8, 16);

        // row 0 all -1, activations 127
        foreach (tw[r, c]) tw[r][c] = (r == 0) ? 3 : 0;
        do_load(15, 7);
        foreach (ta[i]) ta[i] = 127;
        do_comp(); wait_idle();
        chk("t2 beats", got_q.size(), 8);
`ifdef MVM_RELU_EN
        chk("t2 row0", got_q[0], 0);
`else
        chk("t2 row0", got_q[0], -2032);
`endif
        for (int i = 1; i < got_q.size(); i++) chk("t2 rowN", got_q[i], 0);

        // in_len=3, out_len=2; fourth slice must be ignored
        foreach (tw[r, c]) tw[r][c] = (r == 0) ? 1 : 3;
        do_load(2, 1);
        ta[0] = 10; ta[1] = 20; ta[2] = 30; ta[3] = 100;
        do_comp(); wait_idle();
        chk("t3 beats", got_q.size(), 2);
        chk("t3 row0", got_q[0], 60);
        chk("t3 row1", got_q[1], relu(-60));

        // saturation at full in_len
        foreach (tw[r, c]) tw[r][c] = 1;
        do_load(63, 7);
        foreach (ta[i]) ta[i] = 127;
        do_comp(); wait_idle();
        check_all("t4 pos sat", 8, 2047);
        foreach (ta[i]) ta[i] = -128;
        do_comp(); wait_idle();
        check_all("t4 neg sat", 8, relu(-2048));

        // output stall with a word pending on the input side
        foreach (ta[i]) ta[i] = int'($signed(8'($urandom)));
        stall = 5;
        do_comp();
        send_word(16'h1234);
        wait_idle();
        chk("t5 beats", got_q.size(), 8);

        // reset mid-LOAD, then COMP on reset weights
        send_word(16'hA3C7);
        phase = P_LOAD;
        repeat (3) send_word(16'h5555);
        async_reset("t6 load rst");
        foreach (ta[i]) ta[i] = int'($signed(8'($urandom)));
        do_comp(); wait_idle();
        check_all("t6 zero after load rst", 8, 0);

        // reset mid-OUT
        foreach (tw[r, c]) tw[r][c] = int'($urandom_range(0, 3));
        do_load(15, 7);
        stall = 1000;
        do_comp();
        repeat (4) @(posedge clk);
        async_reset("t6 out rst");
        do_comp(); wait_idle();
        check_all("t6 zero after out rst", 8, 0);

        // randomised dims, weights and activations
        for (int it = 0; it < 14; it++) begin
            foreach (tw[r, c]) tw[r][c] = int'($urandom_range(0, 3));
            do_load(int'($urandom_range(0, 63)), int'($urandom_range(0, 10)));
            repeat ($urandom_range(1, 2)) begin
                foreach (ta[i])
                    ta[i] = ($urandom_range(0, 1) != 0) ? int'($signed(8'($urandom)))
                                                        : int'($urandom_range(0, 10)) - 5;
                stall = int'($urandom_range(0, 3));
                do_comp(); wait_idle();
                if ($urandom_range(0, 2) == 0)
                    send_word({4'($urandom_range(0, 9)), 12'($urandom)});
            end
        end

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
